// File: rtl/rv32i_mem_stage_pkg.sv
// Shared encodings for the RV32I memory-access stage: bus widths, funct3
// load/store modes, fault causes and FSM states.
package rv32i_mem_stage_pkg;

    localparam int unsigned DATA_BUS_W     = 32;
    localparam int unsigned REG_ADDR_BUS_W = 5;
    localparam int unsigned RAM_ADDR_BUS_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/rv32i_mem_lane.sv
// Combinational lane logic: store byte-enable/data replication, load lane
// extraction with sign/zero extension, and alignment/illegal-mode checks.
module rv32i_mem_lane
    import rv32i_mem_stage_pkg::*;
(
    input  logic [2:0]  req_mode_i,
    input  logic [1:0]  req_off_i,
    input  logic        req_store_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    output logic        misaligned_o,
    output logic        illegal_o,
    input  logic [2:0]  ld_mode_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shifted;

    // Stores only have B/H/W; loads additionally have the unsigned B/H forms.
    always_comb begin
        illegal_o = 1'b0;
        if (req_store_i) begin
            illegal_o = !(req_mode_i inside {F3_B, F3_H, F3_W});
        end else begin
            illegal_o = !(req_mode_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
    end

    always_comb begin
        misaligned_o = 1'b0;
        case (req_mode_i[1:0])
            2'b01:   misaligned_o = req_off_i[0];
            2'b10:   misaligned_o = (req_off_i != 2'b00);
            default: misaligned_o = 1'b0;
        endcase
    end

    always_comb begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
        if (req_store_i) begin
            case (req_mode_i)
                F3_B: begin
                    st_be_o    = 4'b0001 << req_off_i;
                    st_wdata_o = {4{st_data_i[7:0]}};
                end
                F3_H: begin
                    st_be_o    = req_off_i[1] ? 4'b1100 : 4'b0011;
                    st_wdata_o = {2{st_data_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        ld_data_o = ld_shifted;
        case (ld_mode_i)
            F3_B:    ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3_H:    ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3_BU:   ld_data_o = {24'd0, ld_shifted[7:0]};
            F3_HU:   ld_data_o = {16'd0, ld_shifted[15:0]};
            default: ld_data_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/rv32i_mem_stage.sv
// RV32I memory-access stage with MEM/WB latch: issues one req/ack data-memory
// access at a time, stalls upstream while busy, and reports access faults.
module rv32i_mem_stage
    import rv32i_mem_stage_pkg::*;
#(
    parameter int unsigned DW      = DATA_BUS_W,
    parameter int unsigned AW      = RAM_ADDR_BUS_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_we,
    input  logic [REG_ADDR_BUS_W-1:0] in_waddr,
    input  logic [DW-1:0]             in_wdata,
    input  logic [2:0]                in_mode,
    input  logic                      in_memce,
    input  logic                      in_memwe,
    input  logic [DW-1:0]             in_memdata,
    input  logic [AW-1:0]             in_memaddr,
    output logic                      stall_req,
    output logic                      dm_req,
    output logic                      dm_we,
    output logic [3:0]                dm_be,
    output logic [AW-1:0]             dm_addr,
    output logic [DW-1:0]             dm_wdata,
    input  logic [DW-1:0]             dm_rdata,
    input  logic                      dm_ack,
    output logic                      wb_we,
    output logic [REG_ADDR_BUS_W-1:0] wb_waddr,
    output logic [DW-1:0]             wb_wdata,
    output logic                      fault,
    output logic [1:0]                fault_cause
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [0:0]                state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                mode_q, mode_d;
    logic [1:0]                off_q, off_d;
    logic [REG_ADDR_BUS_W-1:0] waddr_q, waddr_d;
    logic                      we_q, we_d;
    logic                      dm_req_q, dm_req_d;
    logic                      dm_we_q, dm_we_d;
    logic [3:0]                dm_be_q, dm_be_d;
    logic [AW-1:0]             dm_addr_q, dm_addr_d;
    logic [DW-1:0]             dm_wdata_q, dm_wdata_d;
    logic                      wb_we_q, wb_we_d;
    logic [REG_ADDR_BUS_W-1:0] wb_waddr_q, wb_waddr_d;
    logic [DW-1:0]             wb_wdata_q, wb_wdata_d;
    logic                      fault_q, fault_d;
    logic [1:0]                cause_q, cause_d;

    logic [3:0]    st_be;
    logic [DW-1:0] st_wdata;
    logic [DW-1:0] ld_data;
    logic          misaligned;
    logic          illegal;

    rv32i_mem_lane u_lane (
        .req_mode_i   (in_mode),
        .req_off_i    (in_memaddr[1:0]),
        .req_store_i  (in_memwe),
        .st_data_i    (in_memdata),
        .st_be_o      (st_be),
        .st_wdata_o   (st_wdata),
        .misaligned_o (misaligned),
        .illegal_o    (illegal),
        .ld_mode_i    (mode_q),
        .ld_off_i     (off_q),
        .ld_rdata_i   (dm_rdata),
        .ld_data_o    (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mode_q     <= '0;
            off_q      <= '0;
            waddr_q    <= '0;
            we_q       <= 1'b0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_be_q    <= '0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            wb_we_q    <= 1'b0;
            wb_waddr_q <= '0;
            wb_wdata_q <= '0;
            fault_q    <= 1'b0;
            cause_q    <= CAUSE_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            off_q      <= off_d;
            waddr_q    <= waddr_d;
            we_q       <= we_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_be_q    <= dm_be_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            wb_we_q    <= wb_we_d;
            wb_waddr_q <= wb_waddr_d;
            wb_wdata_q <= wb_wdata_d;
            fault_q    <= fault_d;
            cause_q    <= cause_d;
        end
    end

    // Next-state, memory-bus and writeback decisions; fault is a one-cycle pulse.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        off_d      = off_q;
        waddr_d    = waddr_q;
        we_d       = we_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_be_d    = dm_be_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        wb_we_d    = wb_we_q;
        wb_waddr_d = wb_waddr_q;
        wb_wdata_d = wb_wdata_q;
        fault_d    = 1'b0;
        cause_d    = CAUSE_NONE;
        stall_req  = 1'b0;

        if (state_q == ST_IDLE) begin
            if (!in_memce) begin
                wb_we_d    = in_we;
                wb_waddr_d = in_waddr;
                wb_wdata_d = in_wdata;
            end else if (illegal) begin
                wb_we_d = 1'b0;
                fault_d = 1'b1;
                cause_d = CAUSE_ILLEGAL;
            end else if (misaligned) begin
                wb_we_d = 1'b0;
                fault_d = 1'b1;
                cause_d = CAUSE_MISALIGN;
            end else begin
                stall_req  = 1'b1;
                state_d    = ST_BUSY;
                cnt_d      = '0;
                mode_d     = in_mode;
                off_d      = in_memaddr[1:0];
                waddr_d    = in_waddr;
                we_d       = in_we;
                dm_req_d   = 1'b1;
                dm_we_d    = in_memwe;
                dm_be_d    = in_memwe ? st_be : 4'b1111;
                dm_addr_d  = {in_memaddr[AW-1:2], 2'b00};
                dm_wdata_d = st_wdata;
                wb_we_d    = 1'b0;
            end
        end else begin
            if (dm_ack) begin
                // Ack has priority over a coinciding timeout.
                state_d    = ST_IDLE;
                cnt_d      = '0;
                dm_req_d   = 1'b0;
                dm_we_d    = 1'b0;
                wb_waddr_d = waddr_q;
                if (dm_we_q) begin
                    wb_we_d = 1'b0;
                end else begin
                    wb_we_d    = we_q;
                    wb_wdata_d = ld_data;
                end
            end else begin
                stall_req = 1'b1;
                if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    dm_req_d = 1'b0;
                    dm_we_d  = 1'b0;
                    wb_we_d  = 1'b0;
                    fault_d  = 1'b1;
                    cause_d  = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    assign dm_req      = dm_req_q;
    assign dm_we       = dm_we_q;
    assign dm_be       = dm_be_q;
    assign dm_addr     = dm_addr_q;
    assign dm_wdata    = dm_wdata_q;
    assign wb_we       = wb_we_q;
    assign wb_waddr    = wb_waddr_q;
    assign wb_wdata    = wb_wdata_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule
